// File: rtl/renode_mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among NumReq requesters.
// One transaction at a time: grant, issue downstream, wait for the response, return it.
module renode_mem_arbiter #(
  parameter  int NumReq        = 4,
  parameter  int AddrWidth     = 64,
  parameter  int DataWidth     = 64,
  parameter  int TimeoutCycles = 1024,
  localparam int BeWidth       = DataWidth / 8,
  localparam int IdxWidth      = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*BeWidth-1:0]     req_be_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_we_o,
  output logic [BeWidth-1:0]            mem_be_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [DataWidth-1:0]          mem_rsp_rdata_i,
  input  logic                          mem_rsp_err_i,
  output logic                          busy_o,
  output logic [IdxWidth-1:0]           owner_o,
  output logic                          timeout_o
);

  localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int ToLast   = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_next;
  logic [IdxWidth-1:0]   ptr_q, owner_q, sel, next_ptr;
  logic                  found, grant, rsp_take, timeout_hit;
  logic [CntWidth-1:0]   count_q;
  logic [NumReq-1:0]     sel_oh, owner_oh, rsp_pulse_q;
  logic [AddrWidth-1:0]  addr_q, addr_sel;
  logic                  we_q, we_sel;
  logic [BeWidth-1:0]    be_q, be_sel;
  logic [DataWidth-1:0]  wdata_q, wdata_sel, rdata_q;
  logic                  err_q;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_valid_i[(int'(ptr_q) + i) % NumReq]) begin
        sel   = IdxWidth'((int'(ptr_q) + i) % NumReq);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    we_sel    = 1'b0;
    be_sel    = '0;
    wdata_sel = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (IdxWidth'(k) == sel) begin
        addr_sel  = req_addr_i[k*AddrWidth +: AddrWidth];
        we_sel    = req_we_i[k];
        be_sel    = req_be_i[k*BeWidth +: BeWidth];
        wdata_sel = req_wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign sel_oh   = {{(NumReq-1){1'b0}}, 1'b1} << sel;
  assign owner_oh = {{(NumReq-1){1'b0}}, 1'b1} << owner_q;
  assign next_ptr = IdxWidth'((int'(owner_q) + 1) % NumReq);

  // A response arriving in the last allowed cycle beats the timeout.
  assign timeout_hit = (TimeoutCycles != 0) && (state_q != IDLE)
                       && (count_q == CntWidth'(ToLast))
                       && !((state_q == WAIT) && mem_rsp_valid_i);

  always_comb begin
    state_next      = state_q;
    req_ready_o     = '0;
    grant           = 1'b0;
    mem_req_valid_o = 1'b0;
    rsp_take        = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !rst_i) begin
          req_ready_o = sel_oh;
          grant       = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (timeout_hit)          state_next = IDLE;
        else if (mem_req_ready_i) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          rsp_take   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_pulse_q <= '0;
    end else begin
      state_q     <= state_next;
      rsp_pulse_q <= '0;
      if (grant) begin
        owner_q <= sel;
        addr_q  <= addr_sel;
        we_q    <= we_sel;
        be_q    <= be_sel;
        wdata_q <= wdata_sel;
        count_q <= '0;
      end else if (state_q != IDLE) begin
        count_q <= count_q + 1'b1;
      end
      if (rsp_take) begin
        rdata_q     <= mem_rsp_rdata_i;
        err_q       <= mem_rsp_err_i;
        rsp_pulse_q <= owner_oh;
        ptr_q       <= next_ptr;
      end
      // Timed-out response is presented combinationally; keep the held copy consistent.
      if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        ptr_q   <= next_ptr;
      end
    end
  end

  assign rsp_valid_o = rsp_pulse_q | (timeout_hit ? owner_oh : '0);
  assign rsp_rdata_o = timeout_hit ? '0 : rdata_q;
  assign rsp_err_o   = timeout_hit | err_q;
  assign timeout_o   = timeout_hit;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_renode_mem_arbiter.sv
// Directed bench for renode_mem_arbiter (4 requesters, 64-bit, 8-cycle timeout).
// Each cycle: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
module tb_renode_mem_arbiter;

  logic         clk, rst;
  logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [255:0] req_addr, req_wdata;
  logic [31:0]  req_be;
  logic [63:0]  rsp_rdata, mem_addr, mem_wdata, mem_rsp_rdata;
  logic         rsp_err, mem_req_valid, mem_req_ready, mem_we;
  logic [7:0]   mem_be;
  logic         mem_rsp_valid, mem_rsp_err, busy, timeout;
  logic [1:0]   owner;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  renode_mem_arbiter #(
    .NumReq(4), .AddrWidth(64), .DataWidth(64), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_rdata_i(mem_rsp_rdata), .mem_rsp_err_i(mem_rsp_err),
    .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_reqs;
    req_valid = '0;
    req_addr  = '0;
    req_we    = '0;
    req_be    = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int k, input logic [63:0] addr, input logic we,
                         input logic [7:0] be, input logic [63:0] wdata);
    req_valid[k]          = 1'b1;
    req_addr[k*64 +: 64]  = addr;
    req_we[k]             = we;
    req_be[k*8 +: 8]      = be;
    req_wdata[k*64 +: 64] = wdata;
  endtask

  initial begin
    int grants, last_c;
    logic [1:0] prev, e;

    rst = 1'b1;
    clear_reqs();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    tick();
    tick();
    req_valid = 4'hF;
    settle();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_mem_valid", mem_req_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    clear_reqs();

    // 1: single read from requester 2, memory answers late
    set_req(2, 64'h1000, 1'b0, 8'hFF, 64'h0);
    settle();
    check_eq("t1_ready", req_ready, 4'b0100);
    check_eq("t1_busy_idle", busy, 0);
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    settle();
    check_eq("t1_mem_valid", mem_req_valid, 1);
    check_eq("t1_mem_addr", mem_addr, 64'h1000);
    check_eq("t1_mem_we", mem_we, 0);
    check_eq("t1_owner", owner, 2);
    check_eq("t1_ready_issue", req_ready, 0);
    tick();
    mem_req_ready = 1'b0;
    settle();
    check_eq("t1_mem_valid_drop", mem_req_valid, 0);
    tick();
    settle();
    check_eq("t1_no_rsp", rsp_valid, 0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hDEADBEEF;
    settle();
    check_eq("t1_no_rsp_yet", rsp_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    settle();
    check_eq("t1_rsp_valid", rsp_valid, 4'b0100);
    check_eq("t1_rdata", rsp_rdata, 64'hDEADBEEF);
    check_eq("t1_err", rsp_err, 0);
    check_eq("t1_busy_done", busy, 0);
    tick();
    settle();
    check_eq("t1_pulse_once", rsp_valid, 0);
    check_eq("t1_rdata_hold", rsp_rdata, 64'hDEADBEEF);

    // 2: all four requesters valid, zero-wait memory, pointer from reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_valid     = 4'hF;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    grants = 0;
    last_c = 0;
    prev   = '0;
    for (int c = 0; c < 16; c++) begin
      settle();
      if (req_ready != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check_eq("rr_extra_grant", req_ready, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rr_grant", req_ready, 4'b0001 << e);
          if (grants > 0) begin
            check_eq("rr_gap", c - last_c, 3);
            check_eq("rr_rsp", rsp_valid, 4'b0001 << prev);
          end
          last_c = c;
          prev   = e;
          grants++;
        end
      end
      tick();
      if (grants == 5) req_valid = '0;
    end
    settle();
    check_eq("rr_count", grants, 5);
    check_eq("rr_drained", busy, 0);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;

    // 3: write held stable while downstream stalls five cycles
    tick();
    set_req(1, 64'h2000, 1'b1, 8'h0F, 64'h55);
    settle();
    check_eq("t3_ready", req_ready, 4'b0010);
    tick();
    clear_reqs();
    req_be    = '1;
    req_wdata = '1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_req_ready = 1'b1;
      settle();
      check_eq("t3_mem_valid", mem_req_valid, 1);
      check_eq("t3_mem_we", mem_we, 1);
      check_eq("t3_mem_be", mem_be, 8'h0F);
      check_eq("t3_mem_wdata", mem_wdata, 64'h55);
      check_eq("t3_mem_addr", mem_addr, 64'h2000);
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h1234;
    settle();
    check_eq("t3_mem_valid_drop", mem_req_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    clear_reqs();
    settle();
    check_eq("t3_rsp_valid", rsp_valid, 4'b0010);
    check_eq("t3_err", rsp_err, 0);
    check_eq("t3_rdata", rsp_rdata, 64'h1234);

    // 4: memory accepts but never answers
    tick();
    set_req(2, 64'h3000, 1'b0, 8'hFF, 64'h0);
    settle();
    check_eq("t4_ready", req_ready, 4'b0100);
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    settle();
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_eq("t4_timeout_early", timeout, 0);
      tick();
    end
    settle();
    check_eq("t4_timeout", timeout, 1);
    check_eq("t4_rsp_valid", rsp_valid, 4'b0100);
    check_eq("t4_err", rsp_err, 1);
    check_eq("t4_rdata", rsp_rdata, 0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hBAD;
    settle();
    check_eq("t4_timeout_once", timeout, 0);
    check_eq("t4_late_ignored", rsp_valid, 0);
    check_eq("t4_idle", busy, 0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check_eq("t4_late_no_pulse", rsp_valid, 0);
    check_eq("t4_rdata_hold", rsp_rdata, 0);
    check_eq("t4_err_hold", rsp_err, 1);
    set_req(3, 64'h4000, 1'b0, 8'hFF, 64'h0);
    settle();
    check_eq("t4_next_ready", req_ready, 4'b1000);
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    settle();
    check_eq("t4_next_addr", mem_addr, 64'h4000);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h77;
    settle();
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check_eq("t4_next_rsp", rsp_valid, 4'b1000);
    check_eq("t4_next_rdata", rsp_rdata, 64'h77);
    check_eq("t4_next_err", rsp_err, 0);

    // 5: response lands in the timeout cycle
    tick();
    set_req(0, 64'h5000, 1'b0, 8'hFF, 64'h0);
    settle();
    check_eq("t5_ready", req_ready, 4'b0001);
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    settle();
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_eq("t5_timeout_early", timeout, 0);
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hC0DE;
    settle();
    check_eq("t5_no_timeout", timeout, 0);
    check_eq("t5_no_rsp_yet", rsp_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check_eq("t5_rsp_valid", rsp_valid, 4'b0001);
    check_eq("t5_rdata", rsp_rdata, 64'hC0DE);
    check_eq("t5_err", rsp_err, 0);
    check_eq("t5_timeout_after", timeout, 0);

    // 6: reset while waiting for the response
    tick();
    set_req(3, 64'h6000, 1'b0, 8'hFF, 64'h0);
    settle();
    check_eq("t6_ready", req_ready, 4'b1000);
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    check_eq("t6_busy_wait", busy, 1);
    rst           = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h99;
    req_valid     = 4'b1010;
    settle();
    check_eq("t6_mem_valid", mem_req_valid, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_owner", owner, 0);
    check_eq("t6_rsp_valid", rsp_valid, 0);
    check_eq("t6_ready_rst", req_ready, 0);
    check_eq("t6_mem_addr", mem_addr, 0);
    check_eq("t6_rdata", rsp_rdata, 0);
    tick();
    settle();
    check_eq("t6_rsp_in_rst", rsp_valid, 0);
    tick();
    rst           = 1'b0;
    mem_rsp_valid = 1'b0;
    settle();
    check_eq("t6_rsp_after", rsp_valid, 0);
    check_eq("t6_first_grant", req_ready, 4'b0010);
    tick();
    clear_reqs();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
